pool_stream: RTL

//   Streaming, multi-channel pooling unit; sequential successor to the combinational averager.

---
 rtl/pool_pkg.sv | 24 ++
 rtl/pool_lane.sv | 57 +++++
 rtl/pool_stream.sv | 85 ++++++++
 3 files changed

// File: rtl/pool_pkg.sv
// Shared constants and sizing helpers for the streaming pooling unit.
package pool_pkg;

    localparam logic MODE_AVG = 1'b0;
    localparam logic MODE_MAX = 1'b1;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result = result + 1;
            v = v >> 1;
        end
        return result;
    endfunction

    // Accumulator width that holds the sum of a full window without wrapping.
    function automatic int acc_width(input int bitwidth, input int window);
        return bitwidth + clog2(window);
    endfunction

endpackage

// File: rtl/pool_lane.sv
// One pooling lane: running sum and running max over a window, plus the registered result.
module pool_lane
    import pool_pkg::*;
#(
    parameter int BITWIDTH = 8,
    parameter int WINDOW   = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       accept,
    input  logic                       first,
    input  logic                       last,
    input  logic                       mode,
    input  logic signed [BITWIDTH-1:0] lane_in,
    output logic signed [BITWIDTH-1:0] result
);

    localparam int ACC_W = acc_width(BITWIDTH, WINDOW);
    localparam logic signed [ACC_W-1:0] WIN_S = ACC_W'(WINDOW);

    logic signed [ACC_W-1:0]    acc_q;
    logic signed [BITWIDTH-1:0] max_q;
    logic signed [ACC_W-1:0]    in_ext;
    logic signed [ACC_W-1:0]    sum;
    logic signed [ACC_W-1:0]    quot;
    logic signed [BITWIDTH-1:0] max_next;
    logic signed [BITWIDTH-1:0] final_val;

    // Signed division truncates toward zero; the quotient of a full window always fits BITWIDTH.
    always_comb begin
        in_ext    = {{(ACC_W-BITWIDTH){lane_in[BITWIDTH-1]}}, lane_in};
        sum       = acc_q + in_ext;
        quot      = sum / WIN_S;
        max_next  = (lane_in > max_q) ? lane_in : max_q;
        final_val = (mode == MODE_MAX) ? max_next : BITWIDTH'(quot);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q  <= '0;
            max_q  <= '0;
            result <= '0;
        end else if (accept) begin
            if (first) begin
                acc_q <= in_ext;
                max_q <= lane_in;
            end else begin
                acc_q <= sum;
                max_q <= max_next;
            end
            if (last) begin
                result <= final_val;
            end
        end
    end

endmodule

// File: rtl/pool_stream.sv
// Streaming multi-channel pooling unit with valid/ready on both sides.
module pool_stream
    import pool_pkg::*;
#(
    parameter int BITWIDTH = 8,
    parameter int WINDOW   = 4,
    parameter int CHANNELS = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         mode,
    input  logic [BITWIDTH*CHANNELS-1:0] in_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic [BITWIDTH*CHANNELS-1:0] out_data,
    output logic                         out_valid,
    input  logic                         out_ready
);

    localparam int CNT_W = (clog2(WINDOW) < 1) ? 1 : clog2(WINDOW);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WINDOW - 1);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_d;
    logic             mode_q;
    logic             mode_d;
    logic             out_valid_d;
    logic             first;
    logic             last;
    logic             accept;

    // Only the closing beat of a window has to wait for a held result to drain.
    always_comb begin
        first    = (cnt == '0);
        last     = (cnt == LAST_CNT);
        in_ready = !(out_valid && !out_ready && last);
        accept   = in_valid && in_ready;
    end

    always_comb begin
        cnt_d       = cnt;
        mode_d      = mode_q;
        out_valid_d = out_valid;
        if (accept) begin
            cnt_d = last ? '0 : cnt + CNT_W'(1);
            if (first) begin
                mode_d = mode;
            end
        end
        if (accept && last) begin
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            mode_q    <= MODE_AVG;
            out_valid <= 1'b0;
        end else begin
            cnt       <= cnt_d;
            mode_q    <= mode_d;
            out_valid <= out_valid_d;
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
        pool_lane #(
            .BITWIDTH(BITWIDTH),
            .WINDOW  (WINDOW)
        ) u_lane (
            .clk    (clk),
            .rst    (rst),
            .accept (accept),
            .first  (first),
            .last   (last),
            .mode   (mode_q),
            .lane_in(in_data[c*BITWIDTH +: BITWIDTH]),
            .result (out_data[c*BITWIDTH +: BITWIDTH])
        );
    end

endmodule
